disp_scheduler: RTL and testbench

- Controller for the 32-bit nibble-rotating 7-segment message scroller.
- Generates the scroll-rate tick from the system clock and shares the display between NREQ message sources using round-robin arbitration.
- Drives the scroller's load enable and load data so that each granted message scrolls for a fixed number of full rotations.
- Sits between the requesting modules and the scroller; the scroller is clocked or enabled by disp_tick.

---
 rtl/disp_sched_pkg.sv | 16 +
 rtl/disp_scheduler_arbiter.sv | 30 +++
 rtl/disp_scheduler.sv | 139 +++++++++++++
 tb/tb_disp_scheduler.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_sched_pkg.sv
// Shared types and constants for the 7-segment message scroller controller.
// Build option: DISP_SCHED_BLANK_EN adds a blank-screen interval after each message.
package disp_sched_pkg;

  localparam int STEPS_PER_ROT = 8;
  localparam int NIBBLE_W      = 4;
  localparam int MSG_W         = STEPS_PER_ROT * NIBBLE_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCROLL = 2'd2,
    BLANK  = 2'd3
  } state_t;

endpackage

// File: rtl/disp_scheduler_arbiter.sv
// Combinational round-robin picker: the first asserted request strictly after
// the last grant, searching upward and wrapping.
module disp_rr_arbiter
  import disp_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int IW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  // Scan from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[IW'((int'(last) + k) % NREQ)]) begin
        any       = 1'b1;
        grant_idx = IW'((int'(last) + k) % NREQ);
      end
    end
    if (any) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/disp_scheduler.sv
// Scroll-rate prescaler plus round-robin message scheduler for the scroller.
// Build option: DISP_SCHED_BLANK_EN inserts a blanking interval after SCROLL.
//
// state  | meaning
// IDLE   | waiting for a request; arbitration happens here only
// LOAD   | disp_data_en high until the scroller takes datain on a tick
// SCROLL | counting 8*ROTATIONS scroll ticks
// BLANK  | zero word loaded on one tick, then 7 dark ticks (optional)
module disp_scheduler
  import disp_sched_pkg::*;
#(
  parameter int TICK_DIV  = 16666667,
  parameter int NREQ      = 4,
  parameter int ROTATIONS = 2,
  localparam int IW     = $clog2(NREQ),
  localparam int STEP_W = $clog2(STEPS_PER_ROT * ROTATIONS),
  localparam int PRE_W  = $clog2(TICK_DIV)
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [MSG_W*NREQ-1:0] msg,
  output logic [NREQ-1:0]       ack,
  output logic                  disp_tick,
  output logic                  disp_data_en,
  output logic [MSG_W-1:0]      datain,
  output logic                  busy,
  output logic [IW-1:0]         cur_src
);

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEPS_PER_ROT * ROTATIONS - 1);
`ifdef DISP_SCHED_BLANK_EN
  localparam logic [STEP_W-1:0] BLANK_LAST = STEP_W'(STEPS_PER_ROT - 1);
`endif

  logic [PRE_W-1:0]  pre_cnt;
  state_t            state, state_nx;
  logic [STEP_W-1:0] step, step_nx;
  logic [MSG_W-1:0]  datain_nx;
  logic [IW-1:0]     cur_src_nx;
  logic [NREQ-1:0]   ack_nx;
  logic [NREQ-1:0]   grant;
  logic [IW-1:0]     grant_idx;
  logic              any;

  disp_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req       (req),
    .last      (cur_src),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any       (any)
  );

  // Free-running prescaler; the tick is registered so it lands the cycle after the wrap value.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pre_cnt   <= '0;
      disp_tick <= 1'b0;
    end else begin
      disp_tick <= (pre_cnt == PRE_LAST);
      pre_cnt   <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state   <= IDLE;
      step    <= '0;
      datain  <= '0;
      cur_src <= IW'(NREQ - 1);
      ack     <= '0;
    end else begin
      state   <= state_nx;
      step    <= step_nx;
      datain  <= datain_nx;
      cur_src <= cur_src_nx;
      ack     <= ack_nx;
    end
  end

  // Next-state logic and scroller handshake outputs.
  always_comb begin
    state_nx     = state;
    step_nx      = step;
    datain_nx    = datain;
    cur_src_nx   = cur_src;
    ack_nx       = '0;
    disp_data_en = 1'b0;
    busy         = (state != IDLE);
    case (state)
      IDLE: begin
        if (any) begin
          datain_nx  = msg[grant_idx*MSG_W +: MSG_W];
          cur_src_nx = grant_idx;
          ack_nx     = grant;
          state_nx   = LOAD;
        end
      end
      LOAD: begin
        disp_data_en = 1'b1;
        if (disp_tick) begin
          state_nx = SCROLL;
          step_nx  = '0;
        end
      end
      SCROLL: begin
        if (disp_tick) begin
          if (step == STEP_LAST) begin
`ifdef DISP_SCHED_BLANK_EN
            state_nx  = BLANK;
            step_nx   = '0;
            datain_nx = '0;
`else
            state_nx  = IDLE;
`endif
          end else begin
            step_nx = step + STEP_W'(1);
          end
        end
      end
      BLANK: begin
`ifdef DISP_SCHED_BLANK_EN
        // Only the first blank tick loads the zero word.
        disp_data_en = (step == '0);
        if (disp_tick) begin
          if (step == BLANK_LAST) state_nx = IDLE;
          else                    step_nx  = step + STEP_W'(1);
        end
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_disp_scheduler.sv
// Scoreboard bench for disp_scheduler: stimulus predicts grants with a
// round-robin model and queues them; a monitor checks every ack and the
// tick-accurate display window that follows it.
`timescale 1ns/1ps
module tb_disp_scheduler;

  localparam int NREQ      = 4;
  localparam int TICK_DIV  = 4;
  localparam int ROTATIONS = 1;
`ifdef DISP_SCHED_BLANK_EN
  localparam int EXP_TICKS = 8*ROTATIONS + 1 + 8;
  localparam int EXP_EN    = 2;
`else
  localparam int EXP_TICKS = 8*ROTATIONS + 1;
  localparam int EXP_EN    = 1;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic [3:0]   req = '0;
  logic [127:0] msg = '0;
  logic [3:0]   ack;
  logic         disp_tick;
  logic         disp_data_en;
  logic [31:0]  datain;
  logic         busy;
  logic [1:0]   cur_src;

  disp_scheduler #(.TICK_DIV(TICK_DIV), .NREQ(NREQ), .ROTATIONS(ROTATIONS)) dut (
    .clk          (clk),
    .clr          (clr),
    .req          (req),
    .msg          (msg),
    .ack          (ack),
    .disp_tick    (disp_tick),
    .disp_data_en (disp_data_en),
    .datain       (datain),
    .busy         (busy),
    .cur_src      (cur_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          src;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   acks_seen = 0;
  int   last_src = NREQ - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (r[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Monitor: pops an expectation on every ack and follows the display window.
  exp_t       cur_e;
  bit         tracking = 1'b0;
  int         ticks = 0;
  int         en_ticks = 0;
  logic [3:0] prev_ack = '0;
  always @(negedge clk) begin
    if (clr) begin
      tracking = 1'b0;
      prev_ack = '0;
    end else begin
      if (prev_ack != '0) check("ack_pulse_len", 32'(ack), 32'd0);
      if (ack != '0) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ack: got ack=%b expected none", ack);
        end else begin
          cur_e = exp_q.pop_front();
          check("ack_onehot", 32'(ack), 32'd1 << cur_e.src);
          check("grant_data", datain, cur_e.data);
          check("cur_src", 32'(cur_src), 32'(cur_e.src));
          check("busy_at_ack", 32'(busy), 32'd1);
          tracking = 1'b1;
          ticks    = 0;
          en_ticks = 0;
        end
        acks_seen++;
      end
      if (tracking) begin
        if (busy) begin
          if (ticks == 0) check("en_until_load_tick", 32'(disp_data_en), 32'd1);
          if (disp_tick) begin
            ticks++;
            if (disp_data_en) begin
              en_ticks++;
              if (en_ticks == 1) check("load_tick_data", datain, cur_e.data);
              else               check("blank_tick_data", datain, 32'd0);
            end
          end
        end else begin
          check("busy_ticks", 32'(ticks), 32'(EXP_TICKS));
          check("en_ticks", 32'(en_ticks), 32'(EXP_EN));
          tracking = 1'b0;
        end
      end
      prev_ack = ack;
    end
  end

  // Tick period: consecutive strobes are TICK_DIV clocks apart.
  int gap = 0;
  bit gap_valid = 1'b0;
  always @(negedge clk) begin
    if (clr) begin
      gap_valid = 1'b0;
      gap       = 0;
    end else if (disp_tick) begin
      if (gap_valid) check("tick_period", 32'(gap + 1), 32'(TICK_DIV));
      gap_valid = 1'b1;
      gap       = 0;
    end else begin
      gap++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rand_msgs();
    for (int i = 0; i < NREQ; i++) msg[32*i +: 32] = $urandom();
  endtask

  task automatic wait_acks(input int n);
    int target;
    int cyc;
    target = acks_seen + n;
    cyc    = 0;
    while (acks_seen < target && cyc < 200*n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (acks_seen < target) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: got %0d acks expected %0d", acks_seen, target);
      exp_q.delete();
    end
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    while (busy && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=1 expected 0");
    end
    cycles(1);
  endtask

  // Hold a pattern for n grants, queueing the predicted winners, then drop it.
  task automatic issue(input logic [3:0] pattern, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.src  = rr_pick(pattern, last_src);
      e.data = msg[32*e.src +: 32];
      exp_q.push_back(e);
      last_src = e.src;
    end
    req = pattern;
    wait_acks(n);
    req = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},     32'(ack),          32'd0);
    check({tag, "_tick"},    32'(disp_tick),    32'd0);
    check({tag, "_en"},      32'(disp_data_en), 32'd0);
    check({tag, "_datain"},  datain,            32'd0);
    check({tag, "_busy"},    32'(busy),         32'd0);
    check({tag, "_cur_src"}, 32'(cur_src),      32'(NREQ - 1));
  endtask

  initial begin
    logic [3:0] pat;
    int         cyc;

    #3 clr = 1'b1;
    #1 check_reset_outputs("rst");
    cycles(2);
    clr = 1'b0;

    for (int i = 0; i < 12; i++) begin
      cycles(1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_en", 32'(disp_data_en), 32'd0);
      check("idle_datain", datain, 32'd0);
    end

    rand_msgs();
    msg[31:0] = 32'h41823205;
    issue(4'b0001, 1);
    wait_idle();

    rand_msgs();
    issue(4'b1111, 5);
    wait_idle();

    rand_msgs();
    issue(4'b0010, 2);
    wait_idle();

    rand_msgs();
    issue(4'b1000, 1);
    cyc = 0;
    while (!(busy && !disp_data_en) && cyc < 100) begin
      cycles(1);
      cyc++;
    end
    check("reached_scroll", 32'(busy && !disp_data_en), 32'd1);
    cycles(5);
    clr = 1'b1;
    #1 check_reset_outputs("midclr");
    cycles(3);
    clr = 1'b0;
    last_src = NREQ - 1;
    exp_q.delete();
    rand_msgs();
    issue(4'b0100, 1);
    wait_idle();

    for (int t = 0; t < 4; t++) begin
      rand_msgs();
      pat = 4'($urandom_range(1, 15));
      issue(pat, 1);
      cycles($urandom_range(2, 20));
      req = 4'($urandom_range(1, 15));
      cycles(3);
      req = '0;
      wait_idle();
    end

    for (int t = 0; t < 20; t++) begin
      cycles($urandom_range(0, 5));
      rand_msgs();
      pat = 4'($urandom_range(1, 15));
      issue(pat, 1);
      wait_idle();
    end

    cycles(2);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
